// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 4-bit ALU: command FIFO, 3-state issue FSM and a valid/ready response port.
// Optional accumulator forwarding is enabled by defining ALU_ACC_FWD_EN.
module alu_cmd_sequencer #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_a,
  input  logic [3:0]    cmd_b,
  input  logic [2:0]    cmd_sel,
  input  logic          cmd_use_acc,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  output logic [2:0]    alu_sel,
  input  logic [3:0]    alu_result,
  input  logic          alu_cout,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [3:0]    rsp_result,
  output logic          rsp_cout,
  output logic          rsp_zero,
  output logic [CW-1:0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
`ifdef ALU_ACC_FWD_EN
  localparam int EW = 12;
`else
  localparam int EW = 11;
`endif

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] entry_in;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;
  logic          fifo_nonempty;
  logic [3:0]    issue_a;

  assign cmd_ready     = (fifo_count < CW'(DEPTH));
  assign push          = cmd_valid & cmd_ready;
  assign fifo_nonempty = (fifo_count != '0);
  // Pops only happen when the FSM is ready to issue, so an empty FIFO is never bypassed.
  assign pop           = fifo_nonempty & ((state == IDLE) | ((state == RESP) & rsp_ready));
  assign head          = mem[rd_ptr];

`ifdef ALU_ACC_FWD_EN
  logic [3:0] acc;

  assign entry_in = {cmd_use_acc, cmd_sel, cmd_b, cmd_a};
  assign issue_a  = head[11] ? acc : head[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 4'd0;
    end else if (state == EXEC) begin
      acc <= alu_result;
    end
  end
`else
  logic unused_use_acc;

  assign unused_use_acc = cmd_use_acc;
  assign entry_in       = {cmd_sel, cmd_b, cmd_a};
  assign issue_a        = head[3:0];
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= entry_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // alu_* keep their last issued values outside a pop so the ALU input never glitches back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      alu_a      <= 4'd0;
      alu_b      <= 4'd0;
      alu_sel    <= 3'd0;
      rsp_valid  <= 1'b0;
      rsp_result <= 4'd0;
      rsp_cout   <= 1'b0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            alu_a   <= issue_a;
            alu_b   <= head[7:4];
            alu_sel <= head[10:8];
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_cout   <= alu_cout;
          rsp_zero   <= (alu_result == 4'd0);
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (pop) begin
              alu_a   <= issue_a;
              alu_b   <= head[7:4];
              alu_sel <= head[10:8];
              state   <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU and reference model.
// Honours ALU_ACC_FWD_EN the same way as the design.
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_a;
  logic [3:0]    cmd_b;
  logic [2:0]    cmd_sel;
  logic          cmd_use_acc;
  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic [2:0]    alu_sel;
  logic [3:0]    alu_result;
  logic          alu_cout;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [3:0]    rsp_result;
  logic          rsp_cout;
  logic          rsp_zero;
  logic [CW-1:0] fifo_count;

  typedef struct packed {
    logic [3:0] result;
    logic       cout;
    logic       zero;
  } rsp_t;

  rsp_t exp_q[$];
  int   hs_cyc[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  logic [3:0] model_acc = 4'd0;
  logic ready_cmd = 1'b0;
  logic rand_ready = 1'b0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero),
    .fifo_count(fifo_count)
  );

  // Stand-in for alu_4bit, combinational from the issued operands.
  logic [4:0] sum;
  always_comb begin
    sum        = 5'd0;
    alu_result = 4'd0;
    alu_cout   = 1'b0;
    case (alu_sel)
      3'd0: begin sum = {1'b0, alu_a} + {1'b0, alu_b}; alu_result = sum[3:0]; alu_cout = sum[4]; end
      3'd1: begin sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1; alu_result = sum[3:0]; alu_cout = sum[4]; end
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: alu_result = ~alu_a;
      3'd6: alu_result = alu_a + 4'd1;
      default: alu_result = alu_a - 4'd1;
    endcase
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      rsp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_cmd;
    end
  end

  function automatic rsp_t ref_model(input int a, input int b, input int sel);
    int   r;
    int   c;
    rsp_t e;
    c = 0;
    case (sel)
      0: begin r = a + b; c = (r > 15) ? 1 : 0; end
      1: begin r = a - b; c = (a >= b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: r = a + 1;
      default: r = a - 1;
    endcase
    r        = r & 15;
    e.result = 4'(r);
    e.cout   = (c != 0);
    e.zero   = (r == 0);
    return e;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Response monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check_output("unexpected rsp", {rsp_result, rsp_cout, rsp_zero}, 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check_output("rsp", {rsp_result, rsp_cout, rsp_zero}, e);
      end
    end
  end

  // Called one time unit after a rising edge; returns at the same phase after acceptance.
  task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b,
                                input logic [2:0] sel, input logic use_acc);
    int   waited;
    logic [3:0] ea;
    rsp_t e;
    waited      = 0;
    cmd_valid   = 1'b1;
    cmd_a       = a;
    cmd_b       = b;
    cmd_sel     = sel;
    cmd_use_acc = use_acc;
    @(negedge clk);
    while (!cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      check_output("cmd accept timeout", 32'(waited), 32'd0);
    end else begin
`ifdef ALU_ACC_FWD_EN
      ea = use_acc ? model_acc : a;
`else
      ea = a;
`endif
      e         = ref_model(int'(ea), int'(b), int'(sel));
      model_acc = e.result;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    cmd_valid  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_output({name, " drained"}, 32'(exp_q.size()), 32'd0);
    check_output({name, " count"}, 32'(fifo_count), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_a       = 4'd0;
    cmd_b       = 4'd0;
    cmd_sel     = 3'd0;
    cmd_use_acc = 1'b0;
    @(negedge clk);
    check_output("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check_output("reset count", 32'(fifo_count), 32'd0);
    check_output("reset rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    ready_cmd = 1'b1;
    step(1);

    // Single ADD and its issue latency
    apply_stimulus(4'd5, 4'd3, 3'd0, 1'b0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("latency", 32'(cyc - accept_cyc), 32'd2);
    drain("add");

    apply_stimulus(4'd5, 4'd3, 3'd1, 1'b0);
    apply_stimulus(4'd3, 4'd5, 3'd1, 1'b0);
    drain("sub");

    apply_stimulus(4'd15, 4'd0, 3'd6, 1'b0);
    drain("inc");

    // Fill while the consumer stalls: one command sits in RESP, DEPTH wait in the FIFO
    ready_cmd = 1'b0;
    step(1);
    apply_stimulus(4'd1, 4'd2, 3'd0, 1'b0);
    apply_stimulus(4'd12, 4'd10, 3'd4, 1'b0);
    apply_stimulus(4'd15, 4'd0, 3'd6, 1'b0);
    apply_stimulus(4'd6, 4'd3, 3'd2, 1'b0);
    apply_stimulus(4'd0, 4'd0, 3'd7, 1'b0);
    step(1);
    check_output("full count", 32'(fifo_count), 32'(DEPTH));
    check_output("full cmd_ready", 32'(cmd_ready), 32'd0);
    check_output("stall rsp_valid", 32'(rsp_valid), 32'd1);
    cmd_valid = 1'b1;
    cmd_a     = 4'd7;
    cmd_b     = 4'd7;
    cmd_sel   = 3'd3;
    step(3);
    check_output("full ignores push", 32'(fifo_count), 32'(DEPTH));
    cmd_valid = 1'b0;
    hs_cyc.delete();
    ready_cmd = 1'b1;
    drain("full");
    check_output("handshakes", 32'(hs_cyc.size()), 32'(DEPTH + 1));
    for (int i = 1; i < hs_cyc.size(); i++) begin
      check_output("throughput gap", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd2);
    end

    // Accumulator chaining: 2+3, then acc (or cmd_a without forwarding) + 1
    apply_stimulus(4'd2, 4'd3, 3'd0, 1'b0);
    apply_stimulus(4'd9, 4'd1, 3'd0, 1'b1);
    drain("acc");

    // Asynchronous reset mid-RESP with three commands still queued
    ready_cmd = 1'b0;
    step(1);
    repeat (4) apply_stimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 1'b0);
    step(1);
    check_output("pre-reset count", 32'(fifo_count), 32'd3);
    check_output("pre-reset rsp_valid", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("arst alu_a", 32'(alu_a), 32'd0);
    check_output("arst alu_b", 32'(alu_b), 32'd0);
    check_output("arst alu_sel", 32'(alu_sel), 32'd0);
    check_output("arst rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("arst rsp", 32'({rsp_result, rsp_cout, rsp_zero}), 32'd0);
    check_output("arst count", 32'(fifo_count), 32'd0);
    check_output("arst cmd_ready", 32'(cmd_ready), 32'd1);
    exp_q.delete();
    model_acc = 4'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1);

    // Randomized traffic with a randomly stalling consumer
    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step($urandom_range(0, 2));
      apply_stimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;
    ready_cmd  = 1'b1;
    drain("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
